// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode values, fetch-stage state encodings and
// instruction-word field positions, used by fetch and the ALU control decoder.
package cpu_defs;

    // Opcode field values (IR[15:13])
    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;
    localparam logic [2:0] OP_XOR     = 3'b100;
    localparam logic [2:0] OP_SHL     = 3'b101;
    localparam logic [2:0] OP_SHR     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    // Fetch-stage state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    // Instruction word layout
    localparam int IR_W    = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RA_MSB  = 12;
    localparam int RA_LSB  = 10;
    localparam int RB_MSB  = 9;
    localparam int RB_LSB  = 7;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;

    // True when the word carries the reserved opcode that stops fetch
    function automatic logic is_illegal(input logic [IR_W-1:0] word);
        return word[OP_MSB:OP_LSB] == OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests one word per fetch, waits for memory,
// presents the decoded fields while issuing, and redirects or increments PC
// when the issued instruction retires. An illegal opcode parks the stage in
// HALT until reset.
module instr_fetch
    import cpu_defs::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic [PC_W-1:0] IMEM_ADDR,
    output logic            IMEM_RD,
    input  logic [15:0]     IMEM_DATA,
    input  logic            IMEM_VALID,
    input  logic            STALL,
    input  logic            BR_TAKEN,
    input  logic [PC_W-1:0] BR_TARGET,
    output logic [2:0]      OP,
    output logic [2:0]      RA,
    output logic [2:0]      RB,
    output logic [6:0]      IMM,
    output logic            INSTR_VALID,
    output logic            HALTED
);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [IR_W-1:0] ir;
    logic [IR_W-1:0] ir_nxt;

    // Next-state, PC and IR update; branch inputs only matter on retire
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            ST_IDLE:  state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (IMEM_VALID) begin
                    ir_nxt    = IMEM_DATA;
                    state_nxt = is_illegal(IMEM_DATA) ? ST_HALT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!STALL) begin
                    pc_nxt    = BR_TAKEN ? BR_TARGET : pc + PC_W'(1);
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, PC and IR registers; reset aborts any outstanding fetch
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    assign IMEM_ADDR   = pc;
    assign IMEM_RD     = (state == ST_FETCH);
    assign INSTR_VALID = (state == ST_ISSUE);
    assign HALTED      = (state == ST_HALT);

    assign OP  = ir[OP_MSB:OP_LSB];
    assign RA  = ir[RA_MSB:RA_LSB];
    assign RB  = ir[RB_MSB:RB_LSB];
    assign IMM = ir[IMM_MSB:IMM_LSB];

endmodule
